// File: rtl/axi4_slave_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_slave_wr_arbiter
//  Purpose  : Per-slave AXI4 write-path arbiter for a 2-master crossbar.
//             Grants decoded AW requests from m0 (CPU) and m1 (DMA)
//             round-robin. W beats follow AW-grant order. Each B response
//             returns to the master that issued the write. Outstanding
//             writes are bounded by OUTSTANDING.
//  Ports    : aclk/areset      clock, synchronous active-high reset
//             mN_aw*           AW request/accept per master
//             mN_w*            W beats per master
//             mN_bvalid/bready B handshake per master; m_bid/m_bresp shared
//             s_aw*/s_w*/s_b*  single slave-side write port
//             outstanding      current B-queue occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_slave_wr_arbiter #(
  parameter int ID_WIDTH    = 4,
  parameter int AW_PL_WIDTH = 45,
  parameter int W_PL_WIDTH  = 36,
  parameter int OUTSTANDING = 4
) (
  input  logic                             aclk,
  input  logic                             areset,
  // master 0
  input  logic                             m0_awvalid,
  output logic                             m0_awready,
  input  logic [ID_WIDTH-1:0]              m0_awid,
  input  logic [AW_PL_WIDTH-1:0]           m0_awpl,
  input  logic                             m0_wvalid,
  output logic                             m0_wready,
  input  logic [W_PL_WIDTH-1:0]            m0_wpl,
  input  logic                             m0_wlast,
  output logic                             m0_bvalid,
  input  logic                             m0_bready,
  // master 1
  input  logic                             m1_awvalid,
  output logic                             m1_awready,
  input  logic [ID_WIDTH-1:0]              m1_awid,
  input  logic [AW_PL_WIDTH-1:0]           m1_awpl,
  input  logic                             m1_wvalid,
  output logic                             m1_wready,
  input  logic [W_PL_WIDTH-1:0]            m1_wpl,
  input  logic                             m1_wlast,
  output logic                             m1_bvalid,
  input  logic                             m1_bready,
  // shared B payload
  output logic [ID_WIDTH-1:0]              m_bid,
  output logic [1:0]                       m_bresp,
  // slave
  output logic                             s_awvalid,
  input  logic                             s_awready,
  output logic [ID_WIDTH-1:0]              s_awid,
  output logic [AW_PL_WIDTH-1:0]           s_awpl,
  output logic                             s_wvalid,
  input  logic                             s_wready,
  output logic [W_PL_WIDTH-1:0]            s_wpl,
  output logic                             s_wlast,
  input  logic                             s_bvalid,
  output logic                             s_bready,
  input  logic [ID_WIDTH-1:0]              s_bid,
  input  logic [1:0]                       s_bresp,
  output logic [$clog2(OUTSTANDING+1)-1:0] outstanding
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                 r_state;
  logic                   r_prio;
  logic                   r_gnt;

  // Both queues hold the granted master index in AW order. The W queue
  // drains on wlast, the B queue on the B handshake, so the B queue is
  // always at least as full as the W queue.
  logic [OUTSTANDING-1:0] r_wq_mem;
  logic [PW-1:0]          r_wq_wr;
  logic [PW-1:0]          r_wq_rd;
  logic [CW-1:0]          r_wq_cnt;
  logic [OUTSTANDING-1:0] r_bq_mem;
  logic [PW-1:0]          r_bq_wr;
  logic [PW-1:0]          r_bq_rd;
  logic [CW-1:0]          r_bq_cnt;

  logic w_aw_hs;
  logic w_w_pop;
  logic w_b_pop;
  logic w_bq_full;
  logic w_wq_nempty;
  logic w_bq_nempty;
  logic w_wh;
  logic w_bh;
  logic w_any_req;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_bq_full   = (r_bq_cnt == CW'(OUTSTANDING));
  assign w_wq_nempty = (r_wq_cnt != '0);
  assign w_bq_nempty = (r_bq_cnt != '0);
  assign w_wh        = r_wq_mem[r_wq_rd];
  assign w_bh        = r_bq_mem[r_bq_rd];
  assign w_any_req   = m0_awvalid | m1_awvalid;

  // ---------------- AW path ----------------
  assign s_awvalid  = (r_state == ST_ISSUE);
  assign w_aw_hs    = s_awvalid & s_awready;
  assign s_awid     = !s_awvalid ? '0 : (r_gnt ? m1_awid : m0_awid);
  assign s_awpl     = !s_awvalid ? '0 : (r_gnt ? m1_awpl : m0_awpl);
  assign m0_awready = s_awvalid & ~r_gnt & s_awready;
  assign m1_awready = s_awvalid &  r_gnt & s_awready;

  // ---------------- W path -----------------
  assign s_wvalid  = w_wq_nempty & (w_wh ? m1_wvalid : m0_wvalid);
  assign s_wpl     = !s_wvalid ? '0 : (w_wh ? m1_wpl : m0_wpl);
  assign s_wlast   = s_wvalid & (w_wh ? m1_wlast : m0_wlast);
  assign m0_wready = w_wq_nempty & ~w_wh & s_wready;
  assign m1_wready = w_wq_nempty &  w_wh & s_wready;
  assign w_w_pop   = s_wvalid & s_wready & s_wlast;

  // ---------------- B path -----------------
  assign m0_bvalid = w_bq_nempty & ~w_bh & s_bvalid;
  assign m1_bvalid = w_bq_nempty &  w_bh & s_bvalid;
  assign s_bready  = w_bq_nempty & (w_bh ? m1_bready : m0_bready);
  assign m_bid     = (w_bq_nempty & s_bvalid) ? s_bid   : '0;
  assign m_bresp   = (w_bq_nempty & s_bvalid) ? s_bresp : 2'b00;
  assign w_b_pop   = s_bvalid & s_bready;

  assign outstanding = r_bq_cnt;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_prio   <= 1'b0;
      r_gnt    <= 1'b0;
      r_wq_mem <= '0;
      r_wq_wr  <= '0;
      r_wq_rd  <= '0;
      r_wq_cnt <= '0;
      r_bq_mem <= '0;
      r_bq_wr  <= '0;
      r_bq_rd  <= '0;
      r_bq_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A full B queue blocks new grants until a B pop frees a slot.
          if (w_any_req && !w_bq_full) begin
            r_state <= ST_ISSUE;
            r_gnt   <= (m0_awvalid && m1_awvalid) ? r_prio : m1_awvalid;
          end
        end
        ST_ISSUE: begin
          if (s_awready) begin
            r_state <= ST_IDLE;
            r_prio  <= ~r_gnt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_aw_hs) begin
        r_wq_mem[r_wq_wr] <= r_gnt;
        r_wq_wr           <= ptr_inc(r_wq_wr);
        r_bq_mem[r_bq_wr] <= r_gnt;
        r_bq_wr           <= ptr_inc(r_bq_wr);
      end
      if (w_w_pop) begin
        r_wq_rd <= ptr_inc(r_wq_rd);
      end
      if (w_b_pop) begin
        r_bq_rd <= ptr_inc(r_bq_rd);
      end
      r_wq_cnt <= r_wq_cnt + CW'(w_aw_hs) - CW'(w_w_pop);
      r_bq_cnt <= r_bq_cnt + CW'(w_aw_hs) - CW'(w_b_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_slave_wr_arbiter
//  Purpose  : Scoreboard bench for axi4_slave_wr_arbiter. Two random master
//             drivers and a random in-order slave; a monitor predicts the
//             grant, W routing and B routing from the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_slave_wr_arbiter;

  localparam int IDW  = 4;
  localparam int AWW  = 45;
  localparam int WW   = 36;
  localparam int OUT  = 4;
  localparam int CW   = $clog2(OUT + 1);
  localparam int MAXA = 128;
  localparam int MAXW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           areset;
  logic [1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [IDW-1:0] m_awid [2];
  logic [AWW-1:0] m_awpl [2];
  logic [WW-1:0]  m_wpl  [2];
  logic [IDW-1:0] m_bid;
  logic [1:0]     m_bresp;
  logic           s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [IDW-1:0] s_awid, s_bid;
  logic [AWW-1:0] s_awpl;
  logic [WW-1:0]  s_wpl;
  logic [1:0]     s_bresp;
  logic [CW-1:0]  outstanding;

  axi4_slave_wr_arbiter #(
    .ID_WIDTH(IDW), .AW_PL_WIDTH(AWW), .W_PL_WIDTH(WW), .OUTSTANDING(OUT)
  ) dut (
    .aclk(clk), .areset(areset),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awid(m_awid[0]), .m0_awpl(m_awpl[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wpl(m_wpl[0]), .m0_wlast(m_wlast[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awid(m_awid[1]), .m1_awpl(m_awpl[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wpl(m_wpl[1]), .m1_wlast(m_wlast[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .m_bid(m_bid), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awpl(s_awpl),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wpl(s_wpl), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .outstanding(outstanding)
  );

  // ---------------- stimulus lists (written by control) ----------------
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     len;
    logic [AWW-1:0] pl;
  } aw_t;

  typedef struct packed {
    logic           m;
    logic [IDW-1:0] id;
    logic [7:0]     len;
  } ord_t;

  aw_t         aw_list [2][MAXA];
  logic [WW:0] w_list  [2][MAXW];   // {last, payload}
  int          n_aw [2] = '{0, 0};
  int          n_w  [2] = '{0, 0};
  int          exp_b = 0;

  logic freeze = 1'b1;   // driver idles all inputs and discards pending work
  logic hold_b = 1'b0;   // slave withholds new B responses
  logic mon_en = 1'b0;   // monitor active; inactive clears the model

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_write(input int m, input logic [IDW-1:0] id, input logic [31:0] addr, input int len);
    aw_t a;
    if (n_aw[m] >= MAXA || n_w[m] + len + 1 > MAXW) return;
    a.id  = id;
    a.len = 8'(len);
    a.pl  = {addr, 8'(len), 3'd2, 2'd1};
    aw_list[m][n_aw[m]] = a;
    n_aw[m]++;
    for (int b = 0; b <= len; b++) begin
      w_list[m][n_w[m]] = {(b == len), 32'($urandom), 4'($urandom)};
      n_w[m]++;
    end
    exp_b++;
  endtask

  // ---------------- master and slave drivers ----------------
  int             aw_idx [2];
  int             w_idx  [2];
  logic [IDW-1:0] sl_ids [$];
  int             sl_wdone;
  int             sl_bcnt;

  task automatic drive_idle();
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    for (int m = 0; m < 2; m++) begin
      m_awid[m] = '0; m_awpl[m] = '0; m_wpl[m] = '0;
    end
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = 2'b00;
  endtask

  initial begin : drv
    logic [1:0]     hs_aw, hs_w;
    logic           s_aw_hs, s_wl_hs, s_b_hs;
    logic [IDW-1:0] s_aw_id;
    drive_idle();
    forever begin
      @(negedge clk);
      hs_aw   = m_awvalid & m_awready;
      hs_w    = m_wvalid & m_wready;
      s_aw_hs = s_awvalid & s_awready;
      s_aw_id = s_awid;
      s_wl_hs = s_wvalid & s_wready & s_wlast;
      s_b_hs  = s_bvalid & s_bready;
      @(posedge clk);
      #1;
      if (freeze) begin
        drive_idle();
        aw_idx = n_aw; w_idx = n_w;
        sl_ids.delete(); sl_wdone = 0; sl_bcnt = 0;
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (hs_aw[m]) aw_idx[m]++;
          if (hs_w[m])  w_idx[m]++;
          if (aw_idx[m] < n_aw[m]) begin
            m_awvalid[m] = 1'b1;
            m_awid[m]    = aw_list[m][aw_idx[m]].id;
            m_awpl[m]    = aw_list[m][aw_idx[m]].pl;
          end else begin
            m_awvalid[m] = 1'b0; m_awid[m] = '0; m_awpl[m] = '0;
          end
          if (w_idx[m] < n_w[m] && ((m_wvalid[m] && !hs_w[m]) || $urandom_range(0, 3) != 0)) begin
            m_wvalid[m] = 1'b1;
            {m_wlast[m], m_wpl[m]} = w_list[m][w_idx[m]];
          end else begin
            m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0; m_wpl[m] = '0;
          end
          m_bready[m] = ($urandom_range(0, 3) != 0);
        end
        if (s_aw_hs) sl_ids.push_back(s_aw_id);
        if (s_wl_hs) sl_wdone++;
        if (s_b_hs)  sl_bcnt++;
        s_awready = ($urandom_range(0, 3) != 0);
        s_wready  = ($urandom_range(0, 3) != 0);
        if (s_bvalid && !s_b_hs) begin
          s_bvalid = 1'b1;   // hold the presented response until accepted
        end else if (!hold_b && sl_bcnt < sl_wdone && sl_bcnt < sl_ids.size()
                     && $urandom_range(0, 2) != 0) begin
          s_bvalid = 1'b1;
          s_bid    = sl_ids[sl_bcnt];
          s_bresp  = 2'($urandom);
        end else begin
          s_bvalid = 1'b0; s_bid = '0; s_bresp = 2'b00;
        end
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  ord_t mq_w [$];
  ord_t mq_b [$];
  int   aw_chk [2];
  int   w_chk  [2];
  int   wbeat, m_cnt, b_done, w_beats;
  logic m_prio, exp_gnt, prev_idle, prev_full;
  logic [1:0] prev_req;

  initial begin : mon
    logic h, push, pop_w, pop_b;
    ord_t o;
    aw_t  a;
    m_prio = 1'b0; exp_gnt = 1'b0; prev_idle = 1'b0; prev_full = 1'b0; prev_req = '0;
    wbeat = 0; m_cnt = 0; b_done = 0; w_beats = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mq_w.delete(); mq_b.delete();
        aw_chk = n_aw; w_chk = n_w;
        wbeat = 0; m_cnt = 0; b_done = 0; w_beats = 0;
        m_prio = 1'b0; prev_idle = 1'b0;
        continue;
      end
      push = 1'b0; pop_w = 1'b0; pop_b = 1'b0;
      chk("outstanding", outstanding, m_cnt);

      // AW: an IDLE cycle with a request and room must issue next cycle.
      if (prev_idle) begin
        if (prev_req != 2'b00 && !prev_full) begin
          chk("aw_issue", s_awvalid, 1);
          exp_gnt = (prev_req == 2'b11) ? m_prio : prev_req[1];
        end else begin
          chk("aw_hold", s_awvalid, 0);
        end
      end
      if (s_awvalid) begin
        chk("awready_gnt", m_awready[exp_gnt], s_awready);
        chk("awready_other", m_awready[!exp_gnt], 0);
        if (s_awready) begin
          if (aw_chk[exp_gnt] < n_aw[exp_gnt]) begin
            a = aw_list[exp_gnt][aw_chk[exp_gnt]];
            chk("s_aw_id_pl", {s_awid, s_awpl}, {a.id, a.pl});
            aw_chk[exp_gnt]++;
            o.m = exp_gnt; o.id = a.id; o.len = a.len;
            push = 1'b1;
          end else begin
            chk("aw_unexpected", 1, 0);
          end
        end
      end else begin
        chk("aw_idle_pl", {m_awready, s_awid, s_awpl}, 0);
      end

      // W: routed from the oldest granted write's master.
      if (mq_w.size() > 0) begin
        h = mq_w[0].m;
        chk("s_wvalid", s_wvalid, m_wvalid[h]);
        chk("wready_head", m_wready[h], s_wready);
        chk("wready_other", m_wready[!h], 0);
        if (s_wvalid && s_wready) begin
          chk("s_w_beat", {s_wlast, s_wpl}, {(wbeat == int'(mq_w[0].len)), w_list[h][w_chk[h]][WW-1:0]});
          w_chk[h]++;
          w_beats++;
          if (wbeat == int'(mq_w[0].len)) begin
            wbeat = 0; pop_w = 1'b1;
          end else begin
            wbeat++;
          end
        end
      end else begin
        chk("w_idle", {s_wvalid, s_wlast, m_wready, s_wpl}, 0);
      end

      // B: returned to the master of the oldest unresponded write.
      if (mq_b.size() > 0) begin
        h = mq_b[0].m;
        chk("bvalid_head", m_bvalid[h], s_bvalid);
        chk("bvalid_other", m_bvalid[!h], 0);
        chk("s_bready", s_bready, m_bready[h]);
        if (s_bvalid) chk("b_id_resp", {m_bid, m_bresp}, {mq_b[0].id, s_bresp});
        if (s_bvalid && s_bready) begin
          pop_b = 1'b1; b_done++;
        end
      end else begin
        chk("b_idle", {s_bready, m_bvalid}, 0);
      end

      prev_idle = !s_awvalid;
      prev_req  = m_awvalid;
      prev_full = (m_cnt == OUT);
      if (push) begin
        mq_w.push_back(o); mq_b.push_back(o);
        m_cnt++;
        m_prio = !exp_gnt;
      end
      if (pop_w) void'(mq_w.pop_front());
      if (pop_b) begin
        void'(mq_b.pop_front());
        m_cnt--;
      end
    end
  end

  // ---------------- control ----------------
  task automatic wait_b(input string nm, input int lim);
    int c = 0;
    while (b_done < exp_b && c < lim) begin
      @(posedge clk); c++;
    end
    #2;
    chk(nm, b_done, exp_b);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, {s_awvalid, s_awid, s_wvalid, s_wlast, s_bready, m_awready,
                       m_wready, m_bvalid, m_bid, m_bresp, outstanding}, 0);
    chk({nm, "_awpl"}, s_awpl, 0);
    chk({nm, "_wpl"}, s_wpl, 0);
  endtask

  initial begin : ctl
    int c, base;
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_reset("reset");
    areset = 1'b0; freeze = 1'b0; mon_en = 1'b1;
    @(posedge clk); #2;

    // single write from m0
    add_write(0, 4'd3, 32'h100, 3);
    wait_b("single_done", 400);

    // both masters contending with single-beat writes
    for (int i = 0; i < 4; i++) begin
      add_write(0, 4'(i), 32'h1000 + 32'(i), 0);
      add_write(1, 4'(8 + i), 32'h2000 + 32'(i), 0);
    end
    wait_b("rr_done", 1000);

    // random mix
    for (int i = 0; i < 40; i++)
      add_write($urandom_range(0, 1), 4'($urandom), $urandom, $urandom_range(0, 3));
    wait_b("rand_done", 5000);

    // outstanding limit: slave withholds B
    hold_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      add_write(0, 4'(i), 32'h3000, 0);
      add_write(1, 4'(i), 32'h4000, 0);
    end
    c = 0;
    while (m_cnt < OUT && c < 500) begin
      @(posedge clk); c++;
    end
    repeat (2) @(posedge clk);
    #2;
    chk("limit_reached", m_cnt, OUT);
    for (int i = 0; i < 10; i++) begin
      chk("limit_awready", m_awready, 0);
      chk("limit_outstanding", outstanding, OUT);
      chk("limit_pending_req", (m_awvalid != 2'b00), 1);
      @(posedge clk); #2;
    end
    hold_b = 1'b0;
    wait_b("limit_done", 1000);

    // reset in the middle of a 4-beat burst
    base = w_beats;
    add_write(0, 4'd5, 32'h200, 3);
    c = 0;
    while (w_beats < base + 1 && c < 500) begin
      @(posedge clk); c++;
    end
    #2;
    chk("midburst_beat1", (w_beats >= base + 1), 1);
    areset = 1'b1; freeze = 1'b1; mon_en = 1'b0;
    @(posedge clk); #2;
    chk_reset("midreset");
    areset = 1'b0; exp_b = 0;
    @(posedge clk); #2;
    chk_reset("postreset");
    freeze = 1'b0; mon_en = 1'b1;
    @(posedge clk); #2;
    add_write(1, 4'd9, 32'h300, 1);
    wait_b("after_reset_done", 400);

    repeat (5) @(posedge clk);
    #2;
    chk("drain_w", mq_w.size(), 0);
    chk("drain_b", mq_b.size(), 0);
    chk("drain_out", outstanding, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
